// File: rtl/cmac_bp_pkg.sv
// Shared types and constants for the CMAC backpressure injector.
// The LFSR helpers are only used when CMAC_BP_INJ_LFSR_EN is defined.
package cmac_bp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_ARM,
        ST_BP
    } bp_state_e;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_POLY)};
    endfunction

endpackage

// File: rtl/cmac_bp_lfsr.sv
// 16-bit pseudo-random source for length jitter; steps once per advance pulse.
module cmac_bp_lfsr
    import cmac_bp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    // Reload the seed on reset so every run after reset sees the same sequence.
    always_ff @(posedge clk) begin
        if (reset)        value <= LFSR_SEED;
        else if (advance) value <= lfsr_next(value);
    end

endmodule

// File: rtl/cmac_bp_injector.sv
// AXI-stream backpressure injector: passes the stream through and periodically
// forces s_axis_tready / m_axis_tvalid low for a configurable number of cycles.
// Optional random length extension: define CMAC_BP_INJ_LFSR_EN.
module cmac_bp_injector
    import cmac_bp_pkg::*;
#(
    parameter int DW    = 512,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     s_axis_tdata,
    input  logic [DW/8-1:0]   s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DW-1:0]     m_axis_tdata,
    output logic [DW/8-1:0]   m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [CNT_W-1:0]  cfg_bp_length,
    input  logic [CNT_W-1:0]  cfg_bp_interval,
    input  logic [CNT_W-1:0]  cfg_bp_count,
    input  logic [15:0]       cfg_len_mask,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              bp_active,
    output logic [CNT_W-1:0]  events_done
);

    bp_state_e        state;
    logic             start_q, stop_q;
    logic [CNT_W-1:0] int_cnt, bp_cnt;
    logic [CNT_W-1:0] len_q, ivl_q, cnt_q;
    logic [CNT_W-1:0] eff_len, ev_inc;
    logic             start_edge, stop_edge, arm_ok, ev_fire, run_done, bp_gate;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;

    // Gating drops as soon as reset is seen, without waiting for the state flop.
    assign bp_gate   = (state == ST_BP) & ~reset;
    assign bp_active = bp_gate;
    assign busy      = (state != ST_IDLE) & ~reset;

    assign s_axis_tready = m_axis_tready & ~bp_gate;
    assign m_axis_tvalid = s_axis_tvalid & ~bp_gate;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    // Never withdraw a beat that is being offered but not yet accepted.
    assign arm_ok = ~(s_axis_tvalid & ~m_axis_tready);

    // An event completes on the last BP cycle, or straight out of ARM for a zero length.
    assign ev_fire = ~stop_edge &
                     (((state == ST_ARM) & arm_ok & (eff_len == '0)) |
                      ((state == ST_BP) & (bp_cnt <= CNT_W'(1))));

    assign ev_inc   = (&events_done) ? events_done : events_done + CNT_W'(1);
    assign run_done = (cnt_q != '0) & (ev_inc == cnt_q);

`ifdef CMAC_BP_INJ_LFSR_EN
    logic [15:0]    lfsr_val, mask_q;
    logic [CNT_W:0] len_sum;

    cmac_bp_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (ev_fire),
        .value   (lfsr_val)
    );

    assign len_sum = {1'b0, len_q} + (CNT_W+1)'(lfsr_val & mask_q);
    assign eff_len = len_sum[CNT_W] ? '1 : len_sum[CNT_W-1:0];

    // Jitter mask is latched alongside the rest of the run configuration.
    always_ff @(posedge clk) begin
        if (reset)                                      mask_q <= '0;
        else if (state == ST_IDLE && start_edge && !stop_edge) mask_q <= cfg_len_mask;
    end
`else
    logic unused_mask;
    assign unused_mask = ^cfg_len_mask;
    assign eff_len     = len_q;
`endif

    // Control FSM: IDLE -> PASS (interval) -> ARM (wait for safe point) -> BP (length).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            int_cnt     <= '0;
            bp_cnt      <= '0;
            events_done <= '0;
            len_q       <= '0;
            ivl_q       <= '0;
            cnt_q       <= '0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            if (stop_edge) begin
                state <= ST_IDLE;
            end else if (ev_fire) begin
                events_done <= ev_inc;
                if (run_done) begin
                    state <= ST_IDLE;
                end else begin
                    state   <= ST_PASS;
                    int_cnt <= ivl_q;
                end
            end else begin
                case (state)
                    ST_IDLE: if (start_edge) begin
                        events_done <= '0;
                        int_cnt     <= cfg_bp_interval;
                        len_q       <= cfg_bp_length;
                        ivl_q       <= cfg_bp_interval;
                        cnt_q       <= cfg_bp_count;
                        state       <= ST_PASS;
                    end
                    // Leave when the count steps down to 1; 0 and 1 both leave at once.
                    ST_PASS: begin
                        if (int_cnt < CNT_W'(3)) state <= ST_ARM;
                        if (int_cnt != '0)       int_cnt <= int_cnt - CNT_W'(1);
                    end
                    ST_ARM: if (arm_ok) begin
                        bp_cnt <= eff_len;
                        state  <= ST_BP;
                    end
                    ST_BP:   bp_cnt <= bp_cnt - CNT_W'(1);
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmac_bp_injector.sv
// Self-checking bench for cmac_bp_injector: table of runs checked by a pulse
// scoreboard, plus hand-written stall / stop / reset / start-stop sequences.
module tb_cmac_bp_injector;

    localparam int DW    = 512;
    localparam int CNT_W = 32;

    logic              clk, reset;
    logic [DW-1:0]     s_axis_tdata, m_axis_tdata;
    logic [DW/8-1:0]   s_axis_tkeep, m_axis_tkeep;
    logic              s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic              m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [CNT_W-1:0]  cfg_bp_length, cfg_bp_interval, cfg_bp_count, events_done;
    logic [15:0]       cfg_len_mask;
    logic              start, stop, busy, bp_active;

    cmac_bp_injector #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .cfg_bp_length(cfg_bp_length), .cfg_bp_interval(cfg_bp_interval),
        .cfg_bp_count(cfg_bp_count), .cfg_len_mask(cfg_len_mask),
        .start(start), .stop(stop), .busy(busy), .bp_active(bp_active),
        .events_done(events_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int gap; int len; } pulse_t;
    typedef struct { int len; int ivl; int cnt; int exp_gap; int exp_events; } vec_t;

    pulse_t exp_q[$];
    vec_t   vecs[6];
    int     errs = 0;
    int     checks = 0;

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Program a run and pulse start; returns at the negedge of the first PASS cycle.
    task automatic kick(input int len, input int ivl, input int cnt, input logic [15:0] mask);
        @(negedge clk);
        cfg_bp_length   = len;
        cfg_bp_interval = ivl;
        cfg_bp_count    = cnt;
        cfg_len_mask    = mask;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bp(input logic lvl, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (bp_active == lvl) ok = 1;
        end
        chk("wait_bp_active", longint'(ok), 1);
    endtask

    // Watch a run with random traffic until busy falls; each finished pulse is
    // popped from the scoreboard and its length and preceding gap compared.
    task automatic run_and_check(input int exp_events, input int exp_cycles);
        int gap = 0, pgap = 0, plen = 0, cyc = 0;
        bit done = 0;
        pulse_t e;
        for (int i = 0; i < 400 && !done; i++) begin
            s_axis_tdata  = {16{$urandom}};
            s_axis_tkeep  = {$urandom, $urandom};
            s_axis_tlast  = 1'($urandom);
            s_axis_tvalid = 1'($urandom);
            #1;
            if (bp_active) begin
                chk("gate_s_tready", longint'(s_axis_tready), 0);
                chk("gate_m_tvalid", longint'(m_axis_tvalid), 0);
                if (plen == 0) pgap = gap;
                plen++;
            end else begin
                chk("pass_tready", longint'(s_axis_tready), longint'(m_axis_tready));
                chk("pass_tvalid", longint'(m_axis_tvalid), longint'(s_axis_tvalid));
                if (plen > 0) begin
                    if (exp_q.size() == 0) chk("unexpected_pulse", plen, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("pulse_len", plen, e.len);
                        chk("pulse_gap", pgap, e.gap);
                    end
                    plen = 0;
                    gap  = 0;
                end
                gap++;
            end
            chk("pass_data", longint'((m_axis_tdata == s_axis_tdata) &&
                (m_axis_tkeep == s_axis_tkeep) && (m_axis_tlast == s_axis_tlast)), 1);
            if (busy) cyc++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        chk("run_timeout", longint'(done), 1);
        chk("run_cycles", cyc, exp_cycles);
        chk("events_done", longint'(events_done), exp_events);
        chk("missing_pulses", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
        cfg_bp_length = '0; cfg_bp_interval = '0; cfg_bp_count = '0; cfg_len_mask = '0;

        // {len, interval, count, expected gap, expected events}
        vecs[0] = '{4, 10, 3, 10, 3};
        vecs[1] = '{1,  2, 2,  2, 2};
        vecs[2] = '{3,  0, 2,  2, 2};
        vecs[3] = '{0,  0, 5,  2, 5};
        vecs[4] = '{2,  5, 1,  5, 1};
        vecs[5] = '{5,  1, 2,  2, 2};

        // Reset state: idle, counters clear, stream passes straight through.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_bp_active", longint'(bp_active), 0);
        chk("rst_events", longint'(events_done), 0);
        chk("rst_s_tready", longint'(s_axis_tready), 0);
        chk("rst_m_tvalid", longint'(m_axis_tvalid), 1);
        reset = 1'b0;
        m_axis_tready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].cnt; k++)
                if (vecs[v].len > 0) exp_q.push_back('{vecs[v].exp_gap, vecs[v].len});
            kick(vecs[v].len, vecs[v].ivl, vecs[v].cnt, 16'h0000);
            run_and_check(vecs[v].exp_events, vecs[v].cnt * (vecs[v].exp_gap + vecs[v].len));
        end

        // Downstream stalled across ARM: BP waits until the offered beat is taken.
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        kick(3, 4, 1, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_bp_active", longint'(bp_active), 0);
            chk("stall_m_tvalid", longint'(m_axis_tvalid), 1);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        #1;
        chk("release_bp_active", longint'(bp_active), 0);
        chk("release_m_tvalid", longint'(m_axis_tvalid), 1);
        @(negedge clk); #1;
        chk("arm_to_bp", longint'(bp_active), 1);
        chk("arm_bp_s_tready", longint'(s_axis_tready), 0);
        begin
            int plen = 1;
            bit ended = 0;
            for (int i = 0; i < 20 && !ended; i++) begin
                @(negedge clk); #1;
                if (bp_active) plen++;
                else ended = 1;
            end
            chk("stall_pulse_len", plen, 3);
        end
        chk("stall_busy", longint'(busy), 0);
        chk("stall_events", longint'(events_done), 1);

        // Stop on the 2nd cycle of an 8-cycle BP; a start mid-run is ignored.
        kick(8, 3, 0, 16'h0000);
        wait_bp(1'b1, 40);
        wait_bp(1'b0, 20);
        chk("stop_first_event", longint'(events_done), 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_bp(1'b1, 20);
        @(negedge clk); #1;
        chk("stop_bp_2nd_cycle", longint'(bp_active), 1);
        stop = 1'b1;
        @(negedge clk); #1;
        chk("stop_bp_active", longint'(bp_active), 0);
        chk("stop_busy", longint'(busy), 0);
        chk("stop_events", longint'(events_done), 1);
        chk("stop_passthru", longint'(s_axis_tready), 1);
        stop = 1'b0;

        // Start and stop edges together: stop wins, block stays idle.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        #1;
        chk("startstop_busy0", longint'(busy), 0);
        @(negedge clk); #1;
        chk("startstop_busy1", longint'(busy), 0);

        // Reset mid-BP: gating released in the same cycle, then a clean rerun.
        s_axis_tvalid = 1'b1;
        kick(6, 3, 0, 16'h0000);
        wait_bp(1'b1, 30);
        reset = 1'b1;
        #1;
        chk("rstbp_bp_active", longint'(bp_active), 0);
        chk("rstbp_s_tready", longint'(s_axis_tready), 1);
        chk("rstbp_m_tvalid", longint'(m_axis_tvalid), 1);
        @(negedge clk); #1;
        chk("rstbp_busy", longint'(busy), 0);
        chk("rstbp_events", longint'(events_done), 0);
        reset = 1'b0;
        exp_q.push_back('{3, 6});
        kick(6, 3, 1, 16'h0000);
        run_and_check(1, 9);

`ifdef CMAC_BP_INJ_LFSR_EN
        // Length jitter: 2 + (lfsr & 3) per event, LFSR freshly seeded by reset.
        do_reset();
        begin
            logic [15:0] l = 16'hACE1;
            int total = 0;
            for (int k = 0; k < 4; k++) begin
                int len = 2 + int'(l & 16'h0003);
                exp_q.push_back('{3, len});
                total += 3 + len;
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            kick(2, 3, 4, 16'h0003);
            run_and_check(4, total);
        end
`else
        // Without the jitter option the mask must have no effect.
        exp_q.push_back('{3, 2});
        exp_q.push_back('{3, 2});
        kick(2, 3, 2, 16'hFFFF);
        run_and_check(2, 10);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cmac_bp_injector.md
CMAC_BP_INJECTOR -- requirements
Module: cmac_bp_injector

Interface
REQ-001 Parameter DW, default 512: AXI-stream tdata width in bits.
REQ-002 Parameter CNT_W, default 32: width of all length, interval and event counters.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata/tkeep/tlast/tvalid  in  DW/DW/8/1/1  upstream stream.
REQ-006 s_axis_tready  out  1  upstream ready; the backpressure injection point.
REQ-007 m_axis_tdata/tkeep/tlast/tvalid  out  DW/DW/8/1/1  downstream stream, passed through combinationally.
REQ-008 m_axis_tready  in  1  downstream ready.
REQ-009 cfg_bp_length  in  CNT_W  backpressure cycles per event.
REQ-010 cfg_bp_interval  in  CNT_W  pass-through cycles between events.
REQ-011 cfg_bp_count  in  CNT_W  number of events per run; 0 means run until stopped.
REQ-012 cfg_len_mask  in  16  random length extension mask; used only when CMAC_BP_INJ_LFSR_EN is defined.
REQ-013 start, stop  in  1/1  rising-edge-detected control strobes.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 bp_active  out  1  high exactly when the block is forcing backpressure.
REQ-016 events_done  out  CNT_W  completed events in the current or last run.

Function
REQ-017 The block SHALL implement the states IDLE, PASS, ARM and BP.
REQ-018 start SHALL be edge-detected against its previous-cycle value; stop likewise.
REQ-019 On a start edge in IDLE, the block SHALL clear events_done, load the interval counter, latch all cfg_* inputs and enter PASS; a start edge outside IDLE SHALL be ignored.
REQ-020 Outside BP, transfers SHALL pass through: s_axis_tready = m_axis_tready; m_axis_tvalid = s_axis_tvalid; data, keep and last are wired through.
REQ-021 In BP, s_axis_tready and m_axis_tvalid SHALL both be 0; bp_active SHALL be 1.
REQ-022 PASS SHALL decrement the interval counter once per cycle and enter ARM when it reaches 1; an interval of 0 SHALL be treated as 1.
REQ-023 ARM SHALL enter BP only on a cycle where !(m_axis_tvalid & !m_axis_tready), so that an offered output beat is never withdrawn.
REQ-024 BP SHALL last exactly the effective length in cycles (count starts on the first BP cycle), then increment events_done and return to PASS.
REQ-025 An effective length of 0 SHALL skip BP; the event still counts.
REQ-026 When events_done reaches a nonzero latched cfg_bp_count, the block SHALL go to IDLE instead of PASS.
REQ-027 A stop edge in any state SHALL force IDLE on the next cycle; a BP in progress SHALL end immediately and SHALL NOT be counted.
REQ-028 If stop and start edges occur in the same cycle, stop SHALL win.
REQ-029 events_done SHALL saturate at all-ones; the event counter SHALL NOT wrap.

Reset
REQ-030 On reset: state = IDLE, busy = 0, bp_active = 0, events_done = 0, all counters = 0, edge-detect history = 0; pass-through SHALL remain active.
REQ-031 Reset asserted mid-BP SHALL release s_axis_tready/m_axis_tvalid gating in the same cycle it is sampled.

Configuration
REQ-032 Macro CMAC_BP_INJ_LFSR_EN: when defined, effective length = latched cfg_bp_length + (lfsr[15:0] & cfg_len_mask), computed in CNT_W bits and saturating at all-ones; the LFSR advances once per event.
REQ-033 When CMAC_BP_INJ_LFSR_EN is undefined, effective length SHALL equal cfg_bp_length, cfg_len_mask SHALL be ignored, and no LFSR logic SHALL be instantiated.

Structure
REQ-034 Package cmac_bp_pkg SHALL hold the state enumeration, the LFSR seed (16'hACE1) and the LFSR polynomial (x^16+x^14+x^13+x^11+1).
REQ-035 The LFSR SHALL be a sub-module, cmac_bp_lfsr, with ports clk, reset, advance and value[15:0]; it is instantiated only under CMAC_BP_INJ_LFSR_EN.

Verification
REQ-036 Scenario: length=4, interval=10, count=3, continuous upstream valid, m_axis_tready=1 -> three 4-cycle bp_active pulses with 10-cycle gaps, events_done=3, busy falls.
REQ-037 Scenario: m_axis_tready=0 when ARM is reached, released after 5 cycles -> BP starts the cycle after the beat is accepted; m_axis_tvalid never drops while unaccepted.
REQ-038 Scenario: stop edge on the 2nd cycle of an 8-cycle BP -> bp_active=0 next cycle, IDLE, events_done unchanged.
REQ-039 Scenario: length=0, interval=0, count=5 -> bp_active never asserts, events_done=5 after 5 PASS cycles.
REQ-040 Scenario: reset pulse mid-BP with count=0 -> all outputs at reset values and pass-through restored; a subsequent start edge runs normally.
REQ-041 Scenario: with LFSR enabled, length=2, mask=16'h0003 -> every BP pulse is 2-5 cycles and the pulse sequence matches the reference LFSR model.
